// File: rtl/axis_rand_health_monitor.sv
// rtl/axis_rand_health_monitor.sv - online health check (count, signature, bias, repeat) for a random AXI-Stream
module axis_rand_health_monitor #(
    parameter int DATA_WIDTH   = 256,
    parameter int WINDOW_LOG2  = 10,
    parameter int BIAS_TOL     = 2048,
    parameter int STALL_PERIOD = 0
) (
    input  logic                     axis_aclk,
    input  logic                     axis_areset,
    input  logic                     axis_rand_in_tvalid,
    output logic                     axis_rand_in_tready,
    input  logic [DATA_WIDTH-1:0]    axis_rand_in_tdata,
    input  logic                     enable,
    input  logic                     clear,
    output logic [31:0]              beat_count,
    output logic [31:0]              signature,
    output logic [WINDOW_LOG2+8:0]   window_ones,
    output logic                     window_done,
    output logic                     bias_error,
    output logic                     repeat_error,
    output logic [15:0]              repeat_count
);
    localparam int WO_W = WINDOW_LOG2 + 9;
    localparam int PC_W = $clog2(DATA_WIDTH + 1);
    localparam int SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
    localparam logic [WO_W-1:0] HALF   = WO_W'((2 ** WINDOW_LOG2) * DATA_WIDTH / 2);
    localparam logic [31:0]     TOL    = 32'(BIAS_TOL);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_REPORT} state_t;
    state_t state, state_nxt;

    logic [SC_W-1:0]        stall_cnt;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [WO_W-1:0]        acc;
    logic [DATA_WIDTH-1:0]  prev_word;
    logic                   prev_valid;
    logic                   stall, accept, win_last, bias_out;
    logic [31:0]            fold;
    logic [PC_W-1:0]        pop;
    logic [WO_W-1:0]        pop_ext, dev;

    assign stall               = (STALL_PERIOD > 0) && (stall_cnt == SC_MAX);
    assign axis_rand_in_tready = (state == S_RUN) && !stall && !clear;
    assign accept              = axis_rand_in_tvalid && axis_rand_in_tready;
    assign win_last            = &win_cnt;
    assign window_done         = (state == S_REPORT);
    assign pop_ext             = WO_W'(pop);

    always_comb begin
        fold = '0;
        for (int i = 0; i < DATA_WIDTH / 32; i++)
            fold = fold ^ axis_rand_in_tdata[i*32 +: 32];
        pop = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            pop = pop + PC_W'(axis_rand_in_tdata[i]);
        dev = (window_ones >= HALF) ? (window_ones - HALF) : (HALF - window_ones);
        bias_out = 32'(dev) > TOL;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (enable && !clear) state_nxt = S_RUN;
            S_RUN: begin
                if (clear)                      state_nxt = S_IDLE;
                else if (accept && win_last)    state_nxt = S_REPORT;
                else if (!enable)               state_nxt = S_IDLE;
            end
            S_REPORT: state_nxt = (enable && !clear) ? S_RUN : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            stall_cnt    <= '0;
            win_cnt      <= '0;
            acc          <= '0;
            prev_word    <= '0;
            prev_valid   <= 1'b0;
            beat_count   <= '0;
            signature    <= '0;
            window_ones  <= '0;
            bias_error   <= 1'b0;
            repeat_error <= 1'b0;
            repeat_count <= '0;
        end else if (clear) begin
            stall_cnt    <= '0;
            win_cnt      <= '0;
            acc          <= '0;
            prev_valid   <= 1'b0;
            beat_count   <= '0;
            signature    <= '0;
            window_ones  <= '0;
            bias_error   <= 1'b0;
            repeat_error <= 1'b0;
            repeat_count <= '0;
        end else begin
            if (state == S_RUN && STALL_PERIOD > 0)
                stall_cnt <= (stall_cnt == SC_MAX) ? '0 : stall_cnt + SC_W'(1);
            if (accept) begin
                beat_count <= beat_count + 32'd1;
                signature  <= {signature[30:0], signature[31]} ^ fold;
                prev_word  <= axis_rand_in_tdata;
                prev_valid <= 1'b1;
                win_cnt    <= win_cnt + WINDOW_LOG2'(1);
                if (prev_valid && axis_rand_in_tdata == prev_word) begin
                    repeat_error <= 1'b1;
                    if (repeat_count != 16'hFFFF) repeat_count <= repeat_count + 16'd1;
                end
                // Window result is captured on the closing beat so REPORT sees it directly.
                if (win_last) begin
                    window_ones <= acc + pop_ext;
                    acc         <= '0;
                end else begin
                    acc <= acc + pop_ext;
                end
            end
            if (state == S_REPORT && bias_out) bias_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_rand_health_monitor.sv
// tb/tb_axis_rand_health_monitor.sv - scoreboard bench for axis_rand_health_monitor
module tb_axis_rand_health_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         a_tvalid = 0, a_tready, a_enable = 0, a_clear = 0;
    logic [255:0] a_tdata = '0;
    logic [31:0]  a_beat_count, a_signature;
    logic [10:0]  a_window_ones;
    logic         a_window_done, a_bias_error, a_repeat_error;
    logic [15:0]  a_repeat_count;

    logic         b_tvalid = 0, b_tready, b_enable = 0, b_clear = 0;
    logic [255:0] b_tdata = '0;
    logic [31:0]  b_beat_count, b_signature;
    logic [14:0]  b_window_ones;
    logic         b_window_done, b_bias_error, b_repeat_error;
    logic [15:0]  b_repeat_count;

    axis_rand_health_monitor #(.DATA_WIDTH(256), .WINDOW_LOG2(2), .BIAS_TOL(511), .STALL_PERIOD(0)) u_a (
        .axis_aclk(clk), .axis_areset(rst),
        .axis_rand_in_tvalid(a_tvalid), .axis_rand_in_tready(a_tready), .axis_rand_in_tdata(a_tdata),
        .enable(a_enable), .clear(a_clear),
        .beat_count(a_beat_count), .signature(a_signature), .window_ones(a_window_ones),
        .window_done(a_window_done), .bias_error(a_bias_error),
        .repeat_error(a_repeat_error), .repeat_count(a_repeat_count));

    axis_rand_health_monitor #(.DATA_WIDTH(256), .WINDOW_LOG2(6), .BIAS_TOL(2048), .STALL_PERIOD(4)) u_b (
        .axis_aclk(clk), .axis_areset(rst),
        .axis_rand_in_tvalid(b_tvalid), .axis_rand_in_tready(b_tready), .axis_rand_in_tdata(b_tdata),
        .enable(b_enable), .clear(b_clear),
        .beat_count(b_beat_count), .signature(b_signature), .window_ones(b_window_ones),
        .window_done(b_window_done), .bias_error(b_bias_error),
        .repeat_error(b_repeat_error), .repeat_count(b_repeat_count));

    typedef struct { logic [10:0] ones; logic bias; } win_t;
    win_t exp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_win(input logic [10:0] ones, input logic bias);
        win_t w;
        w.ones = ones;
        w.bias = bias;
        exp_q.push_back(w);
    endtask

    task automatic send_a(input logic [255:0] d);
        int n = 0;
        a_tvalid = 1'b1;
        a_tdata  = d;
        @(negedge clk);
        while (!a_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_a_ready", a_tready, 1);
        @(posedge clk);
        #1;
        a_tvalid = 1'b0;
    endtask

    // Window monitor: pops an expected window whenever window_done shows, checks bias a cycle later.
    logic a_prev_acc = 1'b0;
    logic bias_pend  = 1'b0;
    logic bias_exp   = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            a_prev_acc = 1'b0;
            bias_pend  = 1'b0;
        end else begin
            if (bias_pend) begin
                chk("bias_after_window", a_bias_error, bias_exp);
                bias_pend = 1'b0;
            end
            if (a_window_done) begin
                chk("done_after_last_beat", {a_prev_acc, a_tready}, 2'b10);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_window: got window_ones %0d expected none", a_window_ones);
                end else begin
                    win_t e;
                    e = exp_q.pop_front();
                    chk("window_ones", a_window_ones, e.ones);
                    bias_pend = 1'b1;
                    bias_exp  = e.bias;
                end
            end
            a_prev_acc = a_tvalid && a_tready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] ones_w, fe_w, five_w;
        ones_w = {256{1'b1}};
        fe_w   = {{255{1'b1}}, 1'b0};
        five_w = {8{32'h5555_5555}};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_tready", a_tready, 0);
        chk("rst_beat_count", a_beat_count, 0);
        chk("rst_window_done", a_window_done, 0);

        // Reset mid-stream
        a_enable = 1'b1;
        step();
        send_a(256'h3);
        send_a(256'h7);
        chk("pre_reset_beats", a_beat_count, 2);
        a_tvalid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tready", a_tready, 0);
        chk("async_rst_beats", a_beat_count, 0);
        chk("async_rst_sig", a_signature, 0);
        a_tvalid = 1'b0;
        a_enable = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("idle_until_enable", a_tready, 0);
        a_enable = 1'b1;
        step();
        chk("run_after_enable", a_tready, 1);

        // Constant pattern window
        push_win(11'd512, 1'b0);
        repeat (4) send_a(five_w);
        step();
        step();
        chk("const_beats", a_beat_count, 4);
        chk("const_rep_err", a_repeat_error, 1);
        chk("const_rep_cnt", a_repeat_count, 3);

        // Clear with tvalid high
        a_clear  = 1'b1;
        a_tvalid = 1'b1;
        a_tdata  = five_w;
        #1;
        chk("clear_tready", a_tready, 0);
        @(posedge clk);
        #1;
        a_clear  = 1'b0;
        a_tvalid = 1'b0;
        chk("clear_beats", a_beat_count, 0);
        chk("clear_rep_err", a_repeat_error, 0);
        chk("clear_rep_cnt", a_repeat_count, 0);
        chk("clear_win_ones", a_window_ones, 0);
        chk("clear_sig", a_signature, 0);

        // Signature and enable drop mid-window
        push_win(11'd513, 1'b0);
        send_a(256'h1);
        chk("sig_one", a_signature, 32'h1);
        send_a(256'h0);
        chk("sig_two", a_signature, 32'h2);
        chk("sig_beats", a_beat_count, 2);
        a_enable = 1'b0;
        step();
        step();
        chk("disabled_tready", a_tready, 0);
        a_enable = 1'b1;
        step();
        send_a(ones_w);
        send_a(ones_w);
        step();
        step();
        chk("resume_sig", a_signature, 32'h8);
        chk("resume_beats", a_beat_count, 4);
        chk("resume_rep_cnt", a_repeat_count, 1);

        // Bias boundary, violation, stickiness
        push_win(11'd1023, 1'b0);
        repeat (3) send_a(ones_w);
        send_a(fe_w);
        push_win(11'd1024, 1'b1);
        repeat (4) send_a(ones_w);
        push_win(11'd512, 1'b1);
        repeat (4) send_a(five_w);
        repeat (3) step();
        chk("long_beats", a_beat_count, 16);
        chk("long_sig", a_signature, 32'h8100);
        chk("long_rep_cnt", a_repeat_count, 10);
        chk("bias_sticky", a_bias_error, 1);
        a_clear = 1'b1;
        step();
        a_clear = 1'b0;
        chk("bias_cleared", a_bias_error, 0);

        // Backpressure on the stalling instance: 40 RUN cycles
        b_enable = 1'b1;
        b_tvalid = 1'b1;
        step();
        for (int k = 1; k <= 40; k++) begin
            b_tdata = {8{32'(k)}};
            if (k == 40) b_enable = 1'b0;
            @(negedge clk);
            chk($sformatf("bp_tready_%0d", k), b_tready, (k % 4) != 0);
            @(posedge clk);
            #1;
        end
        b_tvalid = 1'b0;
        step();
        chk("bp_beats", b_beat_count, 30);
        chk("bp_rep_err", b_repeat_error, 0);
        chk("bp_idle", b_tready, 0);

        repeat (3) step();
        chk("windows_outstanding", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_rand_health_monitor.md
# axis_rand_health_monitor

AXI4-Stream sink that consumes the 256-bit random stream produced by the random stream generator and checks its quality online. It accepts beats under a programmable backpressure pattern and counts them. It folds every beat into a 32-bit signature for golden-model comparison. Per fixed window it counts ones and flags bias, and it flags back-to-back repeated words. It sits at the far end of the random stream as an in-system health check, feeding status registers.

## Interface
- DATA_WIDTH, 256, stream data width; multiple of 32.
- WINDOW_LOG2, 10, window length is 2^WINDOW_LOG2 accepted beats.
- BIAS_TOL, 2048, allowed deviation of window ones count from exact half.
- STALL_PERIOD, 0, 0 means tready never stalls; P>0 means one stall cycle every P RUN cycles.

- axis_aclk  in  1  clock; all logic on rising edge.
- axis_areset  in  1  asynchronous, active-high reset.
- axis_rand_in_tvalid  in  1  upstream beat valid.
- axis_rand_in_tready  out  1  sink ready.
- axis_rand_in_tdata  in  DATA_WIDTH  random word.
- enable  in  1  level; monitor runs while high.
- clear  in  1  synchronous clear of all counters and sticky flags.
- beat_count  out  32  accepted beats since reset/clear; wraps at 2^32.
- signature  out  32  running fold signature.
- window_ones  out  WINDOW_LOG2+9  ones count of the last completed window.
- window_done  out  1  one-cycle pulse: window_ones just updated.
- bias_error  out  1  sticky: some window outside tolerance.
- repeat_error  out  1  sticky: an accepted word equalled the previous accepted word.
- repeat_count  out  16  repeated-word events; saturates at 0xFFFF.

## Operation
- States: IDLE, RUN, REPORT. Reset state IDLE.
- IDLE -> RUN when enable=1 and clear=0.
- RUN -> REPORT on the edge that accepts the 2^WINDOW_LOG2-th beat of the window.
- RUN -> IDLE when enable=0.
- REPORT lasts exactly one cycle. It then goes to RUN if enable=1, otherwise IDLE.
- axis_rand_in_tready = (state==RUN) && !stall && !clear. It is a combinational function of registered state, the stall counter and clear.
- A beat is accepted when tvalid && tready.
- Stall counter: free-running 0..P-1, advancing only in RUN, held elsewhere, reset to 0. stall = (P>0) && counter==P-1.
- On each accepted beat:
  - beat_count increments.
  - signature <= {signature[30:0], signature[31]} ^ fold, where fold = XOR of all DATA_WIDTH/32 32-bit slices of tdata.
  - Window accumulator adds popcount(tdata).
  - Window beat counter increments, wrapping to 0 after the last beat.
  - prev_word <= tdata and prev_valid <= 1.
  - If prev_valid && tdata==prev_word: repeat_error <= 1 and repeat_count increments, saturating at 0xFFFF.
- Last beat of a window: window_ones <= accumulator + popcount(tdata), and the accumulator is zeroed in the same edge.
- In REPORT: window_done = 1. If |window_ones − 2^WINDOW_LOG2·DATA_WIDTH/2| > BIAS_TOL, bias_error is set at the end of REPORT.
- clear=1 for one or more cycles, which dominates everything:
  - tready is low.
  - The following go to 0: beat_count, signature, accumulator, window counter, stall counter, window_ones, prev_valid, bias_error, repeat_error, repeat_count.
  - State goes to IDLE at the next edge.
- Enable dropped mid-window: the accumulator and window counter are kept, and the window resumes on re-enable.
- The enable-low cycle itself can still accept one beat, because state is still RUN.
- Reset values: all outputs and counters 0, state IDLE, prev_valid 0.

## Timing
- tready follows state with zero latency. The first cycle tready can be high is the cycle after enable is sampled high in IDLE.
- All counters, signature and sticky flags update on the edge that accepts the beat. They are visible the following cycle.
- window_done is high during the cycle after the window's last accepted beat. No beat is accepted in that cycle.
- bias_error is visible one cycle after window_done.
- Repeat detection spans windows and REPORT cycles. It does not span clear or reset.
- Asynchronous reset mid-window discards all partial state immediately. tready drops without waiting for an edge.

## Test plan
- Reset: assert axis_areset mid-stream -> tready=0 immediately; all outputs 0; IDLE until enable.
- Constant pattern: WINDOW_LOG2=2, STALL_PERIOD=0, enable, feed 4 beats of 0x5555…55 (128 ones each) -> window_done pulses the cycle after beat 4; window_ones=512; bias_error=0; repeat_error=1; repeat_count=3.
- Bias: 4 beats of all-ones, BIAS_TOL=2048 -> window_ones=1024 (deviation 512 ≤ 2048), bias_error=0. Rerun with BIAS_TOL=100 -> bias_error=1, sticky until clear.
- Signature: one beat with slice0=0x1, other slices 0 -> signature=0x00000001. A second beat of all zeros -> 0x00000002. beat_count=2.
- Backpressure: STALL_PERIOD=4, tvalid held high for 40 RUN cycles -> exactly 30 beats accepted; tready low on every 4th cycle.
- Clear with tvalid high, and enable low mid-window: clear -> no beat accepted, all counters 0. Dropping enable after 2 of 4 window beats, then re-enabling and sending 2 more -> window_done after 4 total beats.
